// File: rtl/neuron_alu_pkg.sv
// neuron_alu_pkg: activation mode encoding and sigmoid-step breakpoints/levels
package neuron_alu_pkg;
  typedef enum logic {ACT_SIGMOID = 1'b0, ACT_RELU = 1'b1} act_mode_t;
  localparam int SIG_BP_LO_OUT = -5;
  localparam int SIG_BP_LO_IN = -3;
  localparam int SIG_BP_HI_IN = 3;
  localparam int SIG_BP_HI_OUT = 5;
  localparam int SIG_LVL_MIN = 0;
  localparam int SIG_LVL_LO = 1;
  localparam int SIG_LVL_MID = 4;
  localparam int SIG_LVL_HI = 7;
  localparam int SIG_LVL_MAX = 8;
endpackage

// File: rtl/neuron_activation.sv
// neuron_activation: z = (acc >>> FRAC_SHIFT) + 2*bias, then sigmoid step or clamped relu
module neuron_activation
  import neuron_alu_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int B_WIDTH = 4,
  parameter int FRAC_SHIFT = 2,
  parameter int OUT_WIDTH = 4
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [B_WIDTH-1:0]   bias,
  input  act_mode_t                   act_mode,
  output logic [OUT_WIDTH-1:0]        act
);
  localparam int ZW = ACC_WIDTH + B_WIDTH + 2;
  localparam logic signed [ZW-1:0] RELU_MAX = ZW'((64'd1 << OUT_WIDTH) - 64'd1);
  logic signed [ZW-1:0] acc_ext, bias_ext, z;
  logic [3:0] lvl;
  logic [OUT_WIDTH-1:0] relu;
  always_comb begin
    acc_ext = ZW'(acc);
    bias_ext = ZW'(bias);
    z = (acc_ext >>> FRAC_SHIFT) + (bias_ext <<< 1);
    lvl = z < SIG_BP_LO_OUT ? 4'(SIG_LVL_MIN) :
          z <= SIG_BP_LO_IN ? 4'(SIG_LVL_LO) :
          z < SIG_BP_HI_IN ? 4'(z + ZW'(SIG_LVL_MID)) :
          z <= SIG_BP_HI_OUT ? 4'(SIG_LVL_HI) : 4'(SIG_LVL_MAX);
    relu = z < 0 ? '0 : z > RELU_MAX ? OUT_WIDTH'(RELU_MAX) : OUT_WIDTH'(z);
    act = act_mode == ACT_RELU ? relu : OUT_WIDTH'(lvl);
  end
endmodule

// File: rtl/neuron_mac_pipeline.sv
// neuron_mac_pipeline: pipelined multi-beat signed MAC with saturating accumulator and activation
module neuron_mac_pipeline
  import neuron_alu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W_WIDTH = 4,
  parameter int X_WIDTH = 4,
  parameter int B_WIDTH = 4,
  parameter int ACC_WIDTH = 16,
  parameter int FRAC_SHIFT = 2,
  parameter int OUT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [LANES*W_WIDTH-1:0]   weights,
  input  logic [LANES*X_WIDTH-1:0]   inputs,
  input  logic [B_WIDTH-1:0]         bias,
  input  logic                       act_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_act,
  output logic [ACC_WIDTH-1:0]       out_acc,
  output logic                       out_ovf
);
  localparam int PW = W_WIDTH + X_WIDTH + $clog2(LANES);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_mode_q, s1_mode_d;
  logic signed [PW-1:0] s1_sum_q, s1_sum_d, prod_sum;
  logic signed [B_WIDTH-1:0] s1_bias_q, s1_bias_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_next, base;
  logic signed [ACC_WIDTH:0] sum_ext;
  logic first_q, first_d, ovf_q, ovf_d, beat_ovf, stall, accept, s2_fire, s2_done;
  logic out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic [OUT_WIDTH-1:0] out_act_q, out_act_d, act_next;
  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < LANES; i++)
      prod_sum += PW'($signed(weights[i*W_WIDTH +: W_WIDTH])) *
                  PW'($signed({1'b0, inputs[i*X_WIDTH +: X_WIDTH]}));
  end
  assign stall = s1_valid_q && s1_last_q && out_valid_q && !out_ready;
  assign in_ready = !stall && !rst;
  assign accept = in_valid && in_ready;
  assign s2_fire = s1_valid_q && !stall;
  assign s2_done = s2_fire && s1_last_q;
  assign base = first_q ? '0 : acc_q;
  assign sum_ext = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(s1_sum_q);
  assign beat_ovf = sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1];
  assign acc_next = beat_ovf ? (sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_ext[ACC_WIDTH-1:0];
  neuron_activation #(
    .ACC_WIDTH(ACC_WIDTH), .B_WIDTH(B_WIDTH), .FRAC_SHIFT(FRAC_SHIFT), .OUT_WIDTH(OUT_WIDTH)
  ) u_act (
    .acc(acc_next), .bias(s1_bias_q), .act_mode(act_mode_t'(s1_mode_q)), .act(act_next)
  );
  always_comb begin
    s1_valid_d = accept ? 1'b1 : s2_fire ? 1'b0 : s1_valid_q;
    s1_last_d = accept ? in_last : s1_last_q;
    s1_mode_d = accept ? act_mode : s1_mode_q;
    s1_sum_d = accept ? prod_sum : s1_sum_q;
    s1_bias_d = accept ? bias : s1_bias_q;
    acc_d = s2_fire ? acc_next : acc_q;
    first_d = s2_fire ? s1_last_q : first_q;
    ovf_d = s2_fire ? ((!first_q && ovf_q) || beat_ovf) : ovf_q;
    out_valid_d = s2_done || (out_valid_q && !out_ready);
    out_acc_d = s2_done ? acc_next : out_acc_q;
    out_ovf_d = s2_done ? ovf_d : out_ovf_q;
    out_act_d = s2_done ? act_next : out_act_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_sum_q <= '0;
      s1_bias_q <= '0;
      acc_q <= '0;
      first_q <= 1'b1;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
      out_act_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q <= s1_last_d;
      s1_mode_q <= s1_mode_d;
      s1_sum_q <= s1_sum_d;
      s1_bias_q <= s1_bias_d;
      acc_q <= acc_d;
      first_q <= first_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q <= out_acc_d;
      out_ovf_q <= out_ovf_d;
      out_act_q <= out_act_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_acc = out_acc_q;
  assign out_ovf = out_ovf_q;
  assign out_act = out_act_q;
endmodule

// File: tb/tb_neuron_mac_pipeline.sv
// tb_neuron_mac_pipeline: directed vectors with queue scoreboard and output-handshake monitor
module tb_neuron_mac_pipeline;
  localparam int LANES = 4, WW = 4, XW = 4, BW = 4, AW = 16, OW = 4;
  typedef struct {int act; int acc; int ovf;} exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, act_mode = 1'b0, out_ready = 1'b1;
  logic [LANES*WW-1:0] weights = '0;
  logic [LANES*XW-1:0] inputs = '0;
  logic [BW-1:0] bias = '0;
  logic in_ready, out_valid, out_ovf;
  logic [OW-1:0] out_act;
  logic [AW-1:0] out_acc;
  exp_t sb[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  neuron_mac_pipeline dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .weights(weights), .inputs(inputs), .bias(bias), .act_mode(act_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_acc(out_acc), .out_ovf(out_ovf)
  );
  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_act", int'(out_act), e.act);
        chk("out_acc", int'($signed(out_acc)), e.acc);
        chk("out_ovf", int'(out_ovf), e.ovf);
      end
    end
  end
  task automatic send(input int w, input int x, input int b, input int m, input int last);
    logic [WW-1:0] wv;
    logic [XW-1:0] xv;
    int n;
    n = 0;
    wv = WW'(w);
    xv = XW'(x);
    weights = {LANES{wv}};
    inputs = {LANES{xv}};
    bias = BW'(b);
    act_mode = m[0];
    in_last = last[0];
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic neuron(input int beats, input int w, input int x, input int b, input int m,
                        input int ea, input int eacc, input int eovf);
    exp_t e;
    e.act = ea;
    e.acc = eacc;
    e.ovf = eovf;
    sb.push_back(e);
    for (int i = 0; i < beats; i++) send(w, x, b, m, int'(i == beats - 1));
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_act", int'(out_act), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    neuron(1, 1, 4, 0, 0, 7, 16, 0);
    chk("lat_cycle1", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", int'(out_valid), 1);
    drain();
    neuron(70, -8, 15, 0, 0, 0, -32768, 1);
    neuron(1, 0, 5, 0, 0, 4, 0, 0);
    neuron(1, 1, 1, 0, 0, 5, 4, 0);
    neuron(1, -1, 4, 0, 0, 1, -16, 0);
    neuron(1, 0, 0, -2, 0, 1, 0, 0);
    neuron(1, 0, 0, 3, 0, 8, 0, 0);
    neuron(1, 1, 4, 0, 1, 4, 16, 0);
    neuron(1, 0, 0, -2, 1, 0, 0, 0);
    neuron(4, 7, 15, 0, 1, 15, 1680, 0);
    drain();
    out_ready = 1'b0;
    neuron(3, 1, 1, 0, 0, 7, 12, 0);
    neuron(3, 2, 1, 0, 0, 8, 24, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_acc", int'($signed(out_acc)), 12);
      chk("bp_hold_act", int'(out_act), 7);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_acc", int'($signed(out_acc)), 24);
    chk("bp_in_ready_back", int'(in_ready), 1);
    drain();
    send(5, 15, 0, 0, 0);
    send(5, 15, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    neuron(1, 1, 4, 0, 0, 7, 16, 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
